// File: rtl/pattern_pkg.sv
// pattern_pkg: shared definitions for the pattern-identification datapath.
//   - Geometry: WORDS, WIDTH, PAT_W, MAX_OFFSET (largest legal pattern LSB).
//   - Initial memory contents, also used by the identifier.
//   - Writer FSM state encoding.
//   - embed_pattern(): replaces PAT_W bits of a word at a given offset.
package pattern_pkg;

  localparam int WORDS      = 4;
  localparam int WIDTH      = 8;
  localparam int PAT_W      = 4;
  localparam int MAX_OFFSET = WIDTH - PAT_W;
  localparam int ADDR_W     = $clog2(WORDS);
  localparam int OFF_W      = 3;

  // PAT_W ones in the low bits of a word; shifted to form the field mask.
  localparam logic [WIDTH-1:0] PAT_MASK = WIDTH'((1 << PAT_W) - 1);

  localparam logic [WIDTH-1:0] INIT_WORD0 = 8'b1011_0011;
  localparam logic [WIDTH-1:0] INIT_WORD1 = 8'b0101_0101;
  localparam logic [WIDTH-1:0] INIT_WORD2 = 8'b1101_1011;
  localparam logic [WIDTH-1:0] INIT_WORD3 = 8'b1101_0001;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MODIFY,
    WRITE,
    VERIFY,
    DONE
  } state_t;

  function automatic logic [WIDTH-1:0] init_word(input logic [ADDR_W-1:0] addr);
    case (addr)
      2'd0:    return INIT_WORD0;
      2'd1:    return INIT_WORD1;
      2'd2:    return INIT_WORD2;
      default: return INIT_WORD3;
    endcase
  endfunction

  // Clears the PAT_W-bit field at 'off' and drops 'pat' into it; all other
  // bits of 'word' are preserved. Shifts are done at full word width.
  function automatic logic [WIDTH-1:0] embed_pattern(input logic [WIDTH-1:0] word,
                                                     input logic [PAT_W-1:0] pat,
                                                     input logic [OFF_W-1:0] off);
    return (word & ~(PAT_MASK << off)) | ({{(WIDTH-PAT_W){1'b0}}, pat} << off);
  endfunction

endpackage

// File: rtl/pattern_mem.sv
// pattern_mem: WORDS x WIDTH register file holding the pattern words.
//   clock, reset   : rising-edge clock, async active-low reset
//   we/waddr/wdata : synchronous write port
//   raddr_a/rdata_a: combinational read port (writer FSM)
//   raddr_b/rdata_b: combinational read port (identifier)
// On reset every word reloads its initial constant from pattern_pkg.
module pattern_mem
  import pattern_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b
);

  logic [WIDTH-1:0] mem [WORDS];

  // NOTE: this array is deliberately reset: the identifier depends on known
  // contents after reset, so it is built from flops, not an inferred RAM.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WORDS; i++) begin
        mem[i] <= init_word(ADDR_W'(i));
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A write lands at the clock edge, so a same-cycle read returns the old word.
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/pattern_writer.sv
// pattern_writer: read-modify-write engine that embeds a 4-bit pattern into
// the pattern memory at a bit offset, and owns that memory.
//   clock, reset : rising-edge clock, async active-low reset
//   start        : request, level-sampled in IDLE only
//   pattern      : pattern to embed
//   offset       : LSB position of the pattern (legal 0..MAX_OFFSET)
//   wr_addr      : target word
//   busy         : high from READ through DONE
//   done         : one-cycle completion pulse
//   err_offset   : one-cycle pulse when a start is rejected (offset too big)
//   write_count  : completed writes, BCD 0..9 wrapping
//   verify_err   : sticky readback mismatch
//   rd_addr/rd_data : combinational identifier read port
// Build option: define PW_VERIFY_EN to insert a VERIFY state after WRITE that
// reads the word back and sets verify_err on mismatch; otherwise verify_err
// is tied to 0 and WRITE goes straight to DONE.
module pattern_writer
  import pattern_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  pattern,
  input  logic [2:0]  offset,
  input  logic [1:0]  wr_addr,
  output logic        busy,
  output logic        done,
  output logic        err_offset,
  output logic [3:0]  write_count,
  output logic        verify_err,
  input  logic [1:0]  rd_addr,
  output logic [7:0]  rd_data
);

  state_t            state, next_state;
  logic [PAT_W-1:0]  pat_q;
  logic [OFF_W-1:0]  off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]  word_q;
  logic [WIDTH-1:0]  new_q;
  logic [WIDTH-1:0]  mem_word;
  logic              offset_ok;
  logic              accept;
  logic              reject;

  assign offset_ok = (offset <= OFF_W'(MAX_OFFSET));
  assign accept    = (state == IDLE) && start && offset_ok;
  assign reject    = (state == IDLE) && start && !offset_ok;

  pattern_mem u_mem (
    .clock   (clock),
    .reset   (reset),
    .we      (state == WRITE),
    .waddr   (addr_q),
    .wdata   (new_q),
    .raddr_a (addr_q),
    .rdata_a (mem_word),
    .raddr_b (rd_addr),
    .rdata_b (rd_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: next_state is defaulted first so no path through the case leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (accept) next_state = READ;
      READ:   next_state = MODIFY;
      MODIFY: next_state = WRITE;
`ifdef PW_VERIFY_EN
      WRITE:  next_state = VERIFY;
      VERIFY: next_state = DONE;
`else
      WRITE:  next_state = DONE;
`endif
      DONE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request capture, datapath and registered status outputs. busy/done are
  // derived from next_state so they are aligned with the state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pat_q       <= '0;
      off_q       <= '0;
      addr_q      <= '0;
      word_q      <= '0;
      new_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_offset  <= 1'b0;
      write_count <= '0;
    end else begin
      if (accept) begin
        pat_q  <= pattern;
        off_q  <= offset;
        addr_q <= wr_addr;
      end
      if (state == READ)   word_q <= mem_word;
      if (state == MODIFY) new_q  <= embed_pattern(word_q, pat_q, off_q);
      if (state == WRITE) begin
        write_count <= (write_count == 4'd9) ? 4'd0 : write_count + 4'd1;
      end
      busy       <= (next_state != IDLE);
      done       <= (next_state == DONE);
      err_offset <= reject;
    end
  end

`ifdef PW_VERIFY_EN
  logic readback_bad;

  // Compare only the embedded field of the written-back word.
  assign readback_bad =
    |((mem_word ^ ({{(WIDTH-PAT_W){1'b0}}, pat_q} << off_q)) & (PAT_MASK << off_q));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                               verify_err <= 1'b0;
    else if (state == VERIFY && readback_bad) verify_err <= 1'b1;
  end
`else
  assign verify_err = 1'b0;
`endif

endmodule

// File: doc/pattern_writer.md
# pattern_writer

Read-modify-write engine that embeds a 4-bit pattern into a 4 × 8-bit pattern memory at a chosen bit offset. It is the writer for the pattern-identification datapath, which scans these words for a 4-bit pattern at offsets 0–4 and counts matches. It owns the memory and provides a combinational read port for the identifier. It also exports a BCD-range write counter for the existing seven-segment path.

## Interface
- WORDS, 4, number of memory words
- WIDTH, 8, word width in bits
- PAT_W, 4, pattern width; legal offsets 0..WIDTH-PAT_W (0..4)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  request; level-sampled in IDLE only
- pattern  in  4  pattern to embed
- offset  in  3  LSB position of pattern within word
- wr_addr  in  2  target word
- busy  out  1  high from READ through DONE
- done  out  1  one-cycle pulse, operation complete
- err_offset  out  1  one-cycle pulse, start rejected (offset > 4)
- write_count  out  4  completed writes, 0..9 wrapping
- verify_err  out  1  sticky readback mismatch (PW_VERIFY_EN only, else 0)
- rd_addr  in  2  identifier read address
- rd_data  out  8  mem[rd_addr], combinational

## Operation
- Memory reset contents: word0 = 10110011, word1 = 01010101, word2 = 11011011, word3 = 11010001.
- Reset values: busy 0, done 0, err_offset 0, write_count 0, verify_err 0, FSM IDLE.
- IDLE state:
  - start=1 with offset ≤ 4: latch pattern, offset and wr_addr into pat_q, off_q and addr_q; go to READ.
  - start=1 with offset > 4: pulse err_offset next cycle; stay in IDLE; memory untouched.
- READ: word_q <= mem[addr_q].
- MODIFY: new_q <= (word_q & ~(4'hF << off_q)) | (pat_q << off_q). Arithmetic is at 8 bits; bits outside [off_q+3:off_q] are preserved.
- WRITE: mem[addr_q] <= new_q; write_count increments, 9 → 0. Writing an unchanged value still counts.
- VERIFY (macro only): if mem[addr_q][off_q +: 4] ≠ pat_q, set verify_err. verify_err clears only on reset.
- DONE: done=1, then return to IDLE.
- start is ignored while busy. If start is still high in IDLE after DONE, a new operation begins (level-sensitive).
- Input changes after capture have no effect on the running operation.

## Timing
- Start sampled at edge E. State sequence: READ at E+1, MODIFY at E+2, WRITE at E+3, DONE at E+4. With the macro, VERIFY is at E+4 and DONE at E+5.
- done and busy are registered. done is high exactly one cycle. busy falls in the cycle after DONE.
- Memory and write_count update at the edge that leaves WRITE.
- When rd_addr equals addr_q during WRITE, rd_data shows the old word; the new word is visible from the next cycle.
- Back-to-back: minimum 5 cycles per operation (6 with the macro), including one IDLE cycle.
- Reset mid-operation: FSM goes to IDLE, memory reloads its initial contents, the partial write is discarded, and no done pulse is issued.

## Configuration
- PW_VERIFY_EN:
  - Defined: VERIFY state is inserted and verify_err is live.
  - Undefined: WRITE goes directly to DONE, and verify_err is tied to 0.

## Structure
- Package pattern_pkg holds:
  - WIDTH, PAT_W and MAX_OFFSET (= 4)
  - memory initial-word constants (shared with the identifier)
  - FSM state encoding: IDLE, READ, MODIFY, WRITE, VERIFY, DONE
- Sub-module pattern_mem: WORDS × WIDTH register file with async reset-load, one sync write port, and two async read ports (one for the FSM, one for rd_addr/rd_data).

## Test plan
- Reset, then rd_addr 0..3 → rd_data 10110011, 01010101, 11011011, 11010001; write_count 0; busy 0.
- start, pattern 0101, offset 2, wr_addr 0:
  - word0 becomes 10010111.
  - done pulses exactly 4 cycles after the start edge (5 with the macro).
  - write_count becomes 1.
- start, pattern 1111, offset 4, wr_addr 1 → word1 becomes 11110101; other words unchanged.
- start with offset 5 → err_offset pulses one cycle; busy stays 0; memory and write_count unchanged.
- Ten consecutive valid writes with start held high → write_count runs 1..9 then 0; a start pulse while busy is ignored.
- Reset asserted during MODIFY → no done pulse; memory back to initial contents; write_count 0; next start proceeds normally.
